// File: rtl/rally_judge_pkg.sv
// Shared types and constants for the rally judge: FSM state encoding, side ids
// and default court geometry.
package judge_pkg;

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_RALLY   = 2'd1,
    ST_POINT   = 2'd2,
    ST_ENDGAME = 2'd3
  } state_e;

  localparam logic SIDE_P1 = 1'b0;
  localparam logic SIDE_P2 = 1'b1;

  localparam int DEF_X_W       = 12;
  localparam int DEF_NET_LEFT  = 500;
  localparam int DEF_NET_RIGHT = 523;

endpackage

// File: rtl/rally_judge_if.sv
// Ball/player event inputs and scoreboard outputs of the rally judge.
interface rally_judge_if #(
  parameter int X_W     = 12,
  parameter int SCORE_W = 4,
  parameter int TOUCH_W = 3
);
  logic               gnd_col;
  logic [X_W-1:0]     xposball;
  logic               collisionsplayer1;
  logic               collisionsplayer2;
  logic [SCORE_W-1:0] score_player1;
  logic [SCORE_W-1:0] score_player2;
  logic [TOUCH_W-1:0] touches_p1;
  logic [TOUCH_W-1:0] touches_p2;
  logic               thirdtouched;
  logic               flag_point;
  logic               point_pulse;
  logic               server;
  logic               endgame;
  logic               winner;

  modport master (
    output gnd_col, xposball, collisionsplayer1, collisionsplayer2,
    input  score_player1, score_player2, touches_p1, touches_p2,
           thirdtouched, flag_point, point_pulse, server, endgame, winner
  );

  modport slave (
    input  gnd_col, xposball, collisionsplayer1, collisionsplayer2,
    output score_player1, score_player2, touches_p1, touches_p2,
           thirdtouched, flag_point, point_pulse, server, endgame, winner
  );
endinterface

// File: rtl/rally_judge_touch_holdoff.sv
// Per-player collision holdoff: load on a counted touch, count down to zero,
// busy while non-zero. Load beats clear.
module touch_holdoff #(
  parameter int HOLDOFF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clr_i,
  output logic busy_o
);
  localparam int CW = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLDOFF - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = LOAD_VAL;
    else if (clr_i)         cnt_d = '0;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/rally_judge.sv
// Volleyball-style rally judge: counts touches, detects faults and ground hits,
// awards points and ends the match. Define JUDGE_WIN_BY_TWO_EN for the deuce rule.
module rally_judge
  import judge_pkg::*;
#(
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 15,
  parameter int MAX_TOUCH     = 3,
  parameter int TOUCH_HOLDOFF = 16_250_000,
  parameter int X_W           = DEF_X_W,
  parameter int NET_LEFT      = DEF_NET_LEFT,
  parameter int NET_RIGHT     = DEF_NET_RIGHT
) (
  input logic          clk,
  input logic          rst,
  rally_judge_if.slave bus
);
  localparam int TW = $clog2(MAX_TOUCH + 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [TW-1:0]      FAULT_T   = TW'(MAX_TOUCH + 1);
  localparam logic [X_W-1:0]     NL        = X_W'(NET_LEFT);
  localparam logic [X_W-1:0]     NR        = X_W'(NET_RIGHT);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [TW-1:0]      t1_q, t1_d, t2_q, t2_d;
  logic third_q, third_d, flag_q, flag_d, pulse_q, pulse_d;
  logic srv_q, srv_d, end_q, end_d, win_q, win_d;
  logic last_q, last_d, ptw_q, ptw_d;

  logic busy1, busy2, elig1, elig2, cnt_en, cnt1, cnt2;
  logic fault1, fault2, gnd_hit, end_rally, ball_win, pt_win, clr_hold;
  logic [SCORE_W-1:0] win_sc, los_sc, new_sc;
  logic margin_ok, won;

  touch_holdoff #(.HOLDOFF(TOUCH_HOLDOFF)) u_hold_p1 (
    .clk(clk), .rst(rst), .load_i(cnt1), .clr_i(clr_hold), .busy_o(busy1)
  );
  touch_holdoff #(.HOLDOFF(TOUCH_HOLDOFF)) u_hold_p2 (
    .clk(clk), .rst(rst), .load_i(cnt2), .clr_i(clr_hold), .busy_o(busy2)
  );

  // A registered over-limit touch count ends the rally ahead of any ground hit.
  assign fault1    = (state_q == ST_RALLY) && (t1_q == FAULT_T);
  assign fault2    = (state_q == ST_RALLY) && (t2_q == FAULT_T);
  assign gnd_hit   = (state_q == ST_RALLY) && bus.gnd_col;
  assign end_rally = fault1 | fault2 | gnd_hit;

  assign elig1  = bus.collisionsplayer1 & ~busy1;
  assign elig2  = bus.collisionsplayer2 & ~busy2;
  assign cnt_en = (state_q == ST_START) || ((state_q == ST_RALLY) && !end_rally);
  assign cnt1   = cnt_en & elig1 & ~elig2;
  assign cnt2   = cnt_en & elig2 & ~elig1;
  assign clr_hold = (state_q == ST_START) || (state_q == ST_POINT);

  assign ball_win = (bus.xposball < NL) ? SIDE_P2 :
                    (bus.xposball > NR) ? SIDE_P1 : ~last_q;
  assign pt_win   = fault1 ? SIDE_P2 : fault2 ? SIDE_P1 : ball_win;

  assign win_sc = (ptw_q == SIDE_P2) ? s2_q : s1_q;
  assign los_sc = (ptw_q == SIDE_P2) ? s1_q : s2_q;
  assign new_sc = (win_sc == SCORE_MAX) ? win_sc : win_sc + 1'b1;

`ifdef JUDGE_WIN_BY_TWO_EN
  assign margin_ok = (int'(new_sc) - int'(los_sc)) >= 2;
`else
  assign margin_ok = 1'b1;
`endif

  assign won = (new_sc == SCORE_MAX) || ((int'(new_sc) >= WIN_SCORE) && margin_ok);

  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    third_d = third_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    srv_d   = srv_q;
    end_d   = end_q;
    win_d   = win_q;
    last_d  = last_q;
    ptw_d   = ptw_q;

    if (cnt1) begin
      t1_d   = t1_q + 1'b1;
      t2_d   = '0;
      last_d = SIDE_P1;
    end else if (cnt2) begin
      t2_d   = t2_q + 1'b1;
      t1_d   = '0;
      last_d = SIDE_P2;
    end

    unique case (state_q)
      ST_START: begin
        third_d = 1'b0;
        if (cnt1 || cnt2) state_d = ST_RALLY;
      end
      ST_RALLY: begin
        if (end_rally) begin
          state_d = ST_POINT;
          ptw_d   = pt_win;
          pulse_d = 1'b1;
          flag_d  = pt_win;
          srv_d   = pt_win;
          if (fault1 || fault2) third_d = 1'b1;
        end
      end
      ST_POINT: begin
        if (ptw_q == SIDE_P2) s2_d = new_sc;
        else                  s1_d = new_sc;
        t1_d = '0;
        t2_d = '0;
        if (won) begin
          state_d = ST_ENDGAME;
          end_d   = 1'b1;
          win_d   = ptw_q;
        end else begin
          state_d = ST_START;
        end
      end
      ST_ENDGAME: ;
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_START;
      s1_q    <= '0;
      s2_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      third_q <= 1'b0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      srv_q   <= 1'b0;
      end_q   <= 1'b0;
      win_q   <= 1'b0;
      last_q  <= 1'b0;
      ptw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      third_q <= third_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      srv_q   <= srv_d;
      end_q   <= end_d;
      win_q   <= win_d;
      last_q  <= last_d;
      ptw_q   <= ptw_d;
    end
  end

  assign bus.score_player1 = s1_q;
  assign bus.score_player2 = s2_q;
  assign bus.touches_p1    = t1_q;
  assign bus.touches_p2    = t2_q;
  assign bus.thirdtouched  = third_q;
  assign bus.flag_point    = flag_q;
  assign bus.point_pulse   = pulse_q;
  assign bus.server        = srv_q;
  assign bus.endgame       = end_q;
  assign bus.winner        = win_q;

endmodule
